// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type and counter-width helper for the button bank.
package button_pkg;

    typedef enum logic {ST_STABLE, ST_SETTLE} state_e;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_chan.sv
// button_chan: one button channel, with synchroniser, debounce FSM, and hold/repeat counters.
// Auto-repeat is compiled in only when BUTTON_REPEAT_EN is defined.
module button_chan
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int LONG_CYC     = 50_000_000,
    parameter int REPEAT_CYC   = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_hold_o,
    output logic press_d_o
);
    localparam int DW = cw(DEBOUNCE_CYC);
    localparam int HW = cw(LONG_CYC + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYC);
    localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYC - 1);

    state_e          st_q, st_d;
    logic [1:0]      sync_q;
    logic [DW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            level_q, level_d, press_q, press_d, release_q, release_d, long_q, long_d;
    logic            s, accept, rep_fire;

    assign s      = sync_q[1];
    assign accept = (st_q == ST_SETTLE) && (s != level_q) && (cnt_q == D_LAST);

`ifdef BUTTON_REPEAT_EN
    localparam int RW = cw(REPEAT_CYC);
    localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYC - 1);
    logic [RW-1:0] rep_q, rep_d;
    logic          held;
    // Repeats only run once the hold counter has saturated, i.e. after long_hold.
    assign held     = level_q && (hold_q == H_MAX);
    assign rep_fire = held && (st_q == ST_STABLE) && (rep_q == R_LAST);
    assign rep_d    = (!held || rep_q == R_LAST) ? '0 : rep_q + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_STABLE;
            sync_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            sync_q    <= {sync_q[0], raw_i};
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    always_comb begin
        st_d = (st_q == ST_STABLE) ? ((s != level_q) ? ST_SETTLE : ST_STABLE)
                                   : ((s == level_q || accept) ? ST_STABLE : ST_SETTLE);
    end

    // A bounce back to the current level drops cnt to 0, restarting the window.
    always_comb begin
        cnt_d     = (st_q == ST_SETTLE && s != level_q && !accept) ? cnt_q + 1'b1 : '0;
        level_d   = accept ? s : level_q;
        press_d   = (accept && s) || rep_fire;
        release_d = accept && !s;
        hold_d    = !level_q ? '0 : (hold_q == H_MAX) ? hold_q : hold_q + 1'b1;
        long_d    = level_q && (hold_q == H_PRE);
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign long_hold_o = long_q;
    assign press_d_o   = press_d;

endmodule

// File: rtl/button_bank.sv
// button_bank: N_BTN debounced push-button channels, with optional active-low inputs and a combined press pulse.
// Define BUTTON_REPEAT_EN to enable auto-repeat after long_hold.
module button_bank
    import button_pkg::*;
#(
    parameter int N_BTN          = 5,
    parameter int DEBOUNCE_CYC   = 20,
    parameter int LONG_CYC       = 50_000_000,
    parameter int REPEAT_CYC     = 10_000_000,
    parameter int BTN_ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] bt_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] release_o,
    output logic [N_BTN-1:0] long_hold_o,
    output logic             any_press_o
);
    logic [N_BTN-1:0] raw, press_d;
    logic             any_q;

    assign raw = (BTN_ACTIVE_LOW != 0) ? ~bt_i : bt_i;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LONG_CYC    (LONG_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_i      (raw[i]),
            .level_o    (level_o[i]),
            .press_o    (press_o[i]),
            .release_o  (release_o[i]),
            .long_hold_o(long_hold_o[i]),
            .press_d_o  (press_d[i])
        );
    end

    // Registered from the channels' next-state press so it lines up with press_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) any_q <= 1'b0;
        else        any_q <= |press_d;
    end

    assign any_press_o = any_q;

endmodule
